// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier controller, its datapath and bench.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACCUM,
    DONE,
    ERR
  } mul_state_e;

  // Datapath strobes plus status, decoded together from the FSM state
  typedef struct packed {
    logic loadA;
    logic loadB;
    logic decB;
    logic loadF;
    logic clear;
    logic busy;
    logic done;
    logic err;
  } mul_ctrl_t;

endpackage

// File: rtl/mul_controller_if.sv
// Handshake, datapath flag and control bundle between the controller and its datapath/host.
interface mul_controller_if import mul_pkg::*; #(
  parameter int unsigned WIDTH = MUL_WIDTH
);

  logic             start;
  logic             ack;
  logic             b_in_zero;
  logic             zero;
  logic             loadA;
  logic             loadB;
  logic             decB;
  logic             loadF;
  logic             clear;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH:0]   iter;

  modport master (
    output start, ack, b_in_zero, zero,
    input  loadA, loadB, decB, loadF, clear, busy, done, err, iter
  );

  modport slave (
    input  start, ack, b_in_zero, zero,
    output loadA, loadB, decB, loadF, clear, busy, done, err, iter
  );

endinterface

// File: rtl/mul_iter_cnt.sv
// Accumulate-cycle counter: synchronous clear, increment, saturates at MAX_ITER.
module mul_iter_cnt #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned MAX_ITER = (2**WIDTH) - 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           inc,
  output logic [WIDTH:0] iter,
  output logic           at_max_c
);

  localparam int unsigned IW = WIDTH + 1;

  logic [WIDTH:0] iter_q;
  logic [WIDTH:0] iter_d;

  assign at_max_c = (iter_q >= IW'(MAX_ITER));
  assign iter     = iter_q;

  always_comb begin
    iter_d = iter_q;
    if (clear) begin
      iter_d = '0;
    end else if (inc && !at_max_c) begin
      iter_d = iter_q + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

endmodule

// File: rtl/mul_controller.sv
// Shift-free multiply controller: loads operands, accumulates until B counts down to zero,
// flags a timeout if zero never arrives, and holds DONE/ERR until acknowledged.
module mul_controller import mul_pkg::*; #(
  parameter int unsigned WIDTH    = MUL_WIDTH,
  parameter int unsigned MAX_ITER = (2**WIDTH) - 1
) (
  input  logic              clk,
  input  logic              rst,
  mul_controller_if.slave   bus
);

  mul_state_e     state_q;
  mul_state_e     state_d;
  logic           bz_q;
  logic           bz_d;
  mul_ctrl_t      ctrl_c;
  logic           cnt_clr_c;
  logic           cnt_inc_c;
  logic           at_max_c;
  logic [WIDTH:0] iter;

  mul_iter_cnt #(
    .WIDTH    (WIDTH),
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clr_c),
    .inc      (cnt_inc_c),
    .iter     (iter),
    .at_max_c (at_max_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bz_q    <= bz_d;
    end
  end

  // Moore decode; only decB/loadF/inc in ACCUM look at zero and saturation
  always_comb begin
    state_d   = state_q;
    bz_d      = bz_q;
    ctrl_c    = '0;
    cnt_clr_c = 1'b0;
    cnt_inc_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = LOAD;
          bz_d      = bus.b_in_zero;
          cnt_clr_c = 1'b1;
        end
      end
      LOAD: begin
        ctrl_c.loadA = 1'b1;
        ctrl_c.loadB = 1'b1;
        ctrl_c.clear = 1'b1;
        ctrl_c.busy  = 1'b1;
        state_d      = bz_q ? DONE : ACCUM;
      end
      ACCUM: begin
        ctrl_c.busy = 1'b1;
        if (bus.zero) begin
          state_d = DONE;
        end else if (!at_max_c) begin
          ctrl_c.decB  = 1'b1;
          ctrl_c.loadF = 1'b1;
          cnt_inc_c    = 1'b1;
        end else begin
          state_d = ERR;
        end
      end
      DONE: begin
        ctrl_c.done = 1'b1;
        if (bus.ack) state_d = IDLE;
      end
      ERR: begin
        ctrl_c.err = 1'b1;
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.loadA = ctrl_c.loadA;
  assign bus.loadB = ctrl_c.loadB;
  assign bus.decB  = ctrl_c.decB;
  assign bus.loadF = ctrl_c.loadF;
  assign bus.clear = ctrl_c.clear;
  assign bus.busy  = ctrl_c.busy;
  assign bus.done  = ctrl_c.done;
  assign bus.err   = ctrl_c.err;
  assign bus.iter  = iter;

endmodule

// File: tb/tb_mul_controller.sv
// Scoreboard bench for mul_controller with a behavioural B down-counter supplying zero.
module tb_mul_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_controller_if #(.WIDTH(2)) bus ();

  mul_controller #(.WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit err;
    int iter;
    int dec;
  } exp_t;

  exp_t sb[$];

  // Datapath stand-in: B register loaded on loadB, decremented on decB
  logic [1:0] b_op   = 2'd0;
  logic [1:0] b_q    = 2'd0;
  logic       stuck0 = 1'b0;

  always @(posedge clk) begin
    if (bus.loadB)     b_q <= b_op;
    else if (bus.decB) b_q <= b_q - 2'd1;
  end

  assign bus.zero = !stuck0 && (b_q == 2'd0);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle safety checks, pops the scoreboard when done/err rises
  int n_dec     = 0;
  int n_load    = 0;
  int hold_iter = 0;
  bit prev_dn   = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      n_dec   = 0;
      n_load  = 0;
      prev_dn = 1'b0;
    end else begin
      exp_t e;
      bit dn;
      chk("onehot_decB_loadB", int'(bus.decB && bus.loadB), 0);
      chk("onehot_loadF_clear", int'(bus.loadF && bus.clear), 0);
      if (bus.loadB) n_load++;
      if (bus.decB)  n_dec++;
      dn = bus.done || bus.err;
      if (dn && !prev_dn) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result_err", int'(bus.err), int'(e.err));
          chk("result_done", int'(bus.done), int'(!e.err));
          chk("result_iter", int'(bus.iter), e.iter);
          chk("result_dec_cycles", n_dec, e.dec);
          chk("result_load_cycles", n_load, 1);
        end
        hold_iter = int'(bus.iter);
        n_dec     = 0;
        n_load    = 0;
      end else if (dn && prev_dn) begin
        chk("iter_hold_in_done_err", int'(bus.iter), hold_iter);
      end
      prev_dn = dn;
    end
  end

  task automatic run_op(input logic [1:0] b, input bit stuck, input bit poke, input bit ack_start,
                        input bit exp_err, input int exp_iter, input int exp_dec);
    exp_t e;
    bit   seen;
    e.err  = exp_err;
    e.iter = exp_iter;
    e.dec  = exp_dec;
    sb.push_back(e);
    b_op          = b;
    stuck0        = stuck;
    bus.b_in_zero = (b == 2'd0);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.b_in_zero = 1'b0;
    if (poke) begin
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.ack   = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.ack   = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done || bus.err;
    end
    if (!seen) chk("completion_timeout", 0, 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    bus.ack   = 1'b1;
    bus.start = ack_start;
    @(posedge clk); #1;
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    chk("idle_after_ack", int'({bus.busy, bus.done, bus.err}), 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.ack       = 1'b0;
    bus.b_in_zero = 1'b0;
    #3;
    chk("reset_outputs", int'({bus.loadA, bus.loadB, bus.decB, bus.loadF, bus.clear,
                              bus.busy, bus.done, bus.err}), 0);
    chk("reset_iter", int'(bus.iter), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // b, stuck, poke, ack_start, exp_err, exp_iter, exp_dec
    run_op(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3);
    run_op(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 3);
    run_op(2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 2, 2);
    run_op(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);

    // Abort in the second ACCUM cycle, then restart on the first edge after reset
    b_op      = 2'd3;
    stuck0    = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("accum2_busy_decB", int'({bus.busy, bus.decB}), 3);
    chk("accum2_iter", int'(bus.iter), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", int'({bus.loadA, bus.loadB, bus.decB, bus.loadF, bus.clear,
                                  bus.busy, bus.done, bus.err}), 0);
    chk("async_rst_iter", int'(bus.iter), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    run_op(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
